// File: rtl/testbasic15_types.sv
// rtl/testbasic15_types.sv - shared message types for TestBasic15 and its feeder
// CompoundType and its reset value, shared by the consumer and the feeder.
package testbasic15_types;

  typedef enum logic {
    read  = 1'b0,
    write = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e       mode;
    logic [31:0] x;
    logic [31:0] y;
  } CompoundType;

  localparam CompoundType COMPOUND_RESET = '{mode: read, x: 32'd0, y: 32'd0};

endpackage

// File: rtl/compound_fifo.sv
// rtl/compound_fifo.sv - DEPTH-entry CompoundType FIFO exposing next-state level/head
// Storage, pointers and occupancy; the wrapper registers the outputs from level_next_o/head_next_o.
module compound_fifo
  import testbasic15_types::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  CompoundType       wdata_i,
  input  logic              pop_i,
  output logic [LVL_W-1:0]  level_o,
  output logic [LVL_W-1:0]  level_next_o,
  output CompoundType       head_next_o
);

  CompoundType             mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    push_ok, pop_ok;

  assign push_ok = push_i && !rst;
  assign pop_ok  = pop_i && !rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // The new head may be the slot being written this cycle, so bypass the write data.
  always_comb begin
    head_next_o = mem_q[rd_ptr_d];
    if (push_ok && (wr_ptr_q == rd_ptr_d)) head_next_o = wdata_i;
  end

  assign level_next_o = level_d;
  assign level_o      = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
  end

endmodule

// File: rtl/compound_feeder.sv
// rtl/compound_feeder.sv - buffered CompoundType producer for the TestBasic15 b_in port
// Registered sync/notify handshakes on both sides plus a delivered-message counter.
module compound_feeder
  import testbasic15_types::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  CompoundType       cmd_in,
  input  logic              cmd_in_sync,
  output logic              cmd_in_notify,
  output CompoundType       out,
  input  logic              out_sync,
  output logic              out_notify,
  output logic [LVL_W-1:0]  level,
  output logic [CNT_W-1:0]  delivered
);

  logic              cmd_in_notify_q, cmd_in_notify_d;
  logic              out_notify_q, out_notify_d;
  CompoundType       out_q, out_d;
  logic [CNT_W-1:0]  delivered_q, delivered_d;
  logic              push, pop;
  logic [LVL_W-1:0]  level_next;
  CompoundType       head_next;

  assign push = cmd_in_sync && cmd_in_notify_q;
  assign pop  = out_sync && out_notify_q;

  compound_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .wdata_i      (cmd_in),
    .pop_i        (pop),
    .level_o      (level),
    .level_next_o (level_next),
    .head_next_o  (head_next)
  );

  // out keeps its last value while empty so the consumer never sees a spurious change.
  always_comb begin
    cmd_in_notify_d = (level_next < LVL_W'(DEPTH));
    out_notify_d    = (level_next != '0);
    out_d           = out_notify_d ? head_next : out_q;
    delivered_d     = pop ? delivered_q + CNT_W'(1) : delivered_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_in_notify_q <= 1'b1;
      out_notify_q    <= 1'b0;
      out_q           <= COMPOUND_RESET;
      delivered_q     <= '0;
    end else begin
      cmd_in_notify_q <= cmd_in_notify_d;
      out_notify_q    <= out_notify_d;
      out_q           <= out_d;
      delivered_q     <= delivered_d;
    end
  end

  assign cmd_in_notify = cmd_in_notify_q;
  assign out_notify    = out_notify_q;
  assign out           = out_q;
  assign delivered     = delivered_q;

endmodule

// File: tb/tb_compound_feeder.sv
// tb/tb_compound_feeder.sv - directed self-checking bench for compound_feeder
// Counter shrunk to 4 bits so the wrap scenario stays short.
module tb_compound_feeder;
  import testbasic15_types::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  CompoundType       cmd_in;
  logic              cmd_in_sync;
  logic              cmd_in_notify;
  CompoundType       out;
  logic              out_sync;
  logic              out_notify;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  delivered;

  int errors = 0;
  int checks = 0;

  compound_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_in        (cmd_in),
    .cmd_in_sync   (cmd_in_sync),
    .cmd_in_notify (cmd_in_notify),
    .out           (out),
    .out_sync      (out_sync),
    .out_notify    (out_notify),
    .level         (level),
    .delivered     (delivered)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_in_sync = 1'b0;
    out_sync = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic CompoundType msg(mode_e m, int unsigned x, int unsigned y);
    CompoundType c;
    c.mode = m;
    c.x = x;
    c.y = y;
    return c;
  endfunction

  task automatic test_reset();
    CompoundType exp;
    exp = msg(read, 0, 0);
    cmd_in = msg(write, 32'hdead, 32'hbeef);
    do_reset();
    checks++; if (cmd_in_notify !== 1'b1) begin errors++; $display("FAIL reset_cmd_in_notify got %b want 1", cmd_in_notify); end
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL reset_out_notify got %b want 0", out_notify); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (delivered !== 4'd0) begin errors++; $display("FAIL reset_delivered got %0d want 0", delivered); end
    checks++; if (out !== exp) begin errors++; $display("FAIL reset_out got %h want %h", out, exp); end
  endtask

  task automatic test_single();
    CompoundType exp;
    exp = msg(write, 32'h1234, 1);
    do_reset();
    cmd_in = exp;
    cmd_in_sync = 1'b1;
    step();
    cmd_in_sync = 1'b0;
    checks++; if (out !== exp) begin errors++; $display("FAIL single_out got %h want %h", out, exp); end
    checks++; if (out_notify !== 1'b1) begin errors++; $display("FAIL single_out_notify got %b want 1", out_notify); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
    out_sync = 1'b1;
    step();
    out_sync = 1'b0;
    checks++; if (delivered !== 4'd1) begin errors++; $display("FAIL single_delivered got %0d want 1", delivered); end
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", out_notify); end
    checks++; if (out !== exp) begin errors++; $display("FAIL single_out_hold got %h want %h", out, exp); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      cmd_in = msg(write, i, 32'h100 + i);
      cmd_in_sync = 1'b1;
      step();
    end
    checks++; if (cmd_in_notify !== 1'b0) begin errors++; $display("FAIL fill_notify got %b want 0", cmd_in_notify); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", level); end
    cmd_in = msg(write, 5, 32'h105);
    step();
    cmd_in_sync = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_ignored_level got %0d want 4", level); end
    checks++; if (out.x !== 32'd1) begin errors++; $display("FAIL fill_head got %0d want 1", out.x); end
    out_sync = 1'b1;
    step();
    out_sync = 1'b0;
    checks++; if (out.x !== 32'd2) begin errors++; $display("FAIL fill_pop_head got %0d want 2", out.x); end
    checks++; if (out.y !== 32'h102) begin errors++; $display("FAIL fill_pop_y got %h want 102", out.y); end
    checks++; if (cmd_in_notify !== 1'b1) begin errors++; $display("FAIL fill_renotify got %b want 1", cmd_in_notify); end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL fill_pop_level got %0d want 3", level); end
    for (int i = 2; i <= 4; i++) begin
      checks++; if (out.x !== 32'(i)) begin errors++; $display("FAIL fill_drain_order got %0d want %0d", out.x, i); end
      out_sync = 1'b1;
      step();
    end
    out_sync = 1'b0;
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL fill_drained got %b want 0", out_notify); end
  endtask

  task automatic test_stream();
    int rx [$];
    int max_level;
    do_reset();
    max_level = 0;
    out_sync = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (out_notify) rx.push_back(int'(out.x));
      cmd_in_sync = (i < 10);
      cmd_in = msg(read, i, 32'h200 + i);
      step();
      if (int'(level) > max_level) max_level = int'(level);
    end
    cmd_in_sync = 1'b0;
    out_sync = 1'b0;
    checks++; if (rx.size() != 10) begin errors++; $display("FAIL stream_count got %0d want 10", rx.size()); end
    for (int k = 0; k < rx.size(); k++) begin
      checks++; if (rx[k] != k) begin errors++; $display("FAIL stream_order idx %0d got %0d want %0d", k, rx[k], k); end
    end
    checks++; if (max_level > 1) begin errors++; $display("FAIL stream_max_level got %0d want <=1", max_level); end
    checks++; if (delivered !== 4'd10) begin errors++; $display("FAIL stream_delivered got %0d want 10", delivered); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_in = msg(write, 32'h30 + i, 0);
      cmd_in_sync = 1'b1;
      step();
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_pre_level got %0d want 3", level); end
    cmd_in = msg(write, 32'h99, 0);
    out_sync = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmd_in_sync = 1'b0;
    out_sync = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL mid_out_notify got %b want 0", out_notify); end
    checks++; if (delivered !== 4'd0) begin errors++; $display("FAIL mid_delivered got %0d want 0", delivered); end
    cmd_in = msg(write, 32'h77, 32'h7);
    cmd_in_sync = 1'b1;
    step();
    cmd_in_sync = 1'b0;
    checks++; if (out.x !== 32'h77) begin errors++; $display("FAIL mid_first_x got %h want 77", out.x); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL mid_first_level got %0d want 1", level); end
    out_sync = 1'b1;
    step();
    out_sync = 1'b0;
    checks++; if (delivered !== 4'd1) begin errors++; $display("FAIL mid_first_delivered got %0d want 1", delivered); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_sync = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      cmd_in_sync = (i < 17);
      cmd_in = msg(write, i, 0);
      step();
      if (i == 15) begin
        checks++; if (delivered !== 4'd15) begin errors++; $display("FAIL wrap_15 got %0d want 15", delivered); end
      end
      if (i == 16) begin
        checks++; if (delivered !== 4'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", delivered); end
      end
    end
    cmd_in_sync = 1'b0;
    out_sync = 1'b0;
    checks++; if (delivered !== 4'd1) begin errors++; $display("FAIL wrap_1 got %0d want 1", delivered); end
    checks++; if (out.x !== 32'd16) begin errors++; $display("FAIL wrap_last_x got %0d want 16", out.x); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_in = msg(read, 0, 0);
    cmd_in_sync = 1'b0;
    out_sync = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_reset_mid();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compound_feeder.md
# compound_feeder

Buffered producer stage in front of `TestBasic15`'s `b_in` port. It accepts `CompoundType` messages from an upstream source over a blocking sync/notify port and stores them in a `DEPTH`-entry FIFO. It presents them in order on an output sync/notify port wired directly to `b_in` / `b_in_sync` / `b_in_notify`. It decouples the upstream source from the consumer's section_a/section_b sequencing and counts delivered messages for debug.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16: width of the delivered-message counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset (sampled on `clk`).
- `cmd_in`  in  `CompoundType`  upstream message (`mode`, `x`, `y`).
- `cmd_in_sync`  in  1  upstream has a valid message.
- `cmd_in_notify`  out  1  this block can accept a message (not full).
- `out`  out  `CompoundType`  head-of-FIFO message; connects to consumer `b_in`.
- `out_sync`  in  1  consumer ready; connects to consumer `b_in_notify`.
- `out_notify`  out  1  message valid (not empty); connects to consumer `b_in_sync`.
- `level`  out  `$clog2(DEPTH+1)`  current FIFO occupancy.
- `delivered`  out  `CNT_W`  number of messages handed downstream; wraps modulo 2^`CNT_W`.

## Operation
- Push: `cmd_in_sync && cmd_in_notify` in a cycle. `cmd_in` is written at the write pointer, and the write pointer increments modulo `DEPTH`.
- Pop: `out_sync && out_notify` in a cycle. The read pointer increments modulo `DEPTH`, and `delivered` increments (wraps from all-ones to 0).
- Push and pop in the same cycle: both happen, and `level` is unchanged.
  - Push cannot occur when full, because `cmd_in_notify` is low.
  - Pop cannot occur when empty, because `out_notify` is low.
- Messages are passed unmodified (`mode`, `x`, `y` bit-exact). Order is strictly FIFO.
- All outputs are registered and computed from next-state:
  - `cmd_in_notify` = (`level_next` < `DEPTH`).
  - `out_notify` = (`level_next` > 0).
  - `out` = entry at `rd_ptr_next`.
  - When empty, `out` holds its last value.
- Reset values:
  - `cmd_in_notify` = 1, `out_notify` = 0, `level` = 0, `delivered` = 0.
  - Pointers = 0.
  - `out` = {`mode`: read, `x`: 0, `y`: 0}. This matches the consumer's internal reset of `compoundType_signal`.
- Reset mid-operation: all buffered messages are discarded. No pop or push is performed in the reset cycle, regardless of `sync` inputs.

## Timing
- Latency: a message pushed in cycle N into an empty FIFO has `out_notify` = 1 and `out` = message in cycle N+1. The earliest pop is cycle N+1.
- Full back-pressure: the push that makes `level` = `DEPTH` in cycle N drops `cmd_in_notify` in cycle N+1. A pop in cycle M re-raises it in cycle M+1.
- Throughput: one push and one pop per cycle sustained when 0 < `level` < `DEPTH`.
- `level` and `delivered` reflect the updates of cycle N from cycle N+1.

## Structure
- Shared package `testbasic15_types`:
  - `CompoundType` and its mode enum (`read`, `write`). Reuse these; do not redefine them.
  - New constant `COMPOUND_RESET` (read, 0, 0) for both blocks' reset values.
- One sub-module, `compound_fifo`, containing:
  - storage array, pointers and occupancy;
  - push/pop inputs;
  - next-state level/head outputs.
- `compound_feeder` wraps it with the registered handshake outputs and the `delivered` counter.

## Test plan
- Reset: assert `rst` for 2 cycles → `cmd_in_notify` = 1, `out_notify` = 0, `level` = 0, `delivered` = 0, `out` = {read, 0, 0}.
- Single message: push {write, 32'h1234, 1} in cycle N with `out_sync` = 0 → cycle N+1 `out` = {write, 32'h1234, 1}, `out_notify` = 1, `level` = 1. Raise `out_sync` → `delivered` = 1 and `out_notify` = 0 one cycle later.
- Fill and back-pressure: with `out_sync` = 0, push x = 1, 2, 3, 4 → after 4th push `cmd_in_notify` = 0, `level` = 4. A 5th `cmd_in_sync` is ignored. One pop → `out.x` = 2 next cycle and `cmd_in_notify` = 1.
- Streaming and wrap-around: push x = 0..9 with `out_sync` held 1 and simultaneous push/pop each cycle → received x sequence is exactly 0..9. `level` never exceeds 1. `delivered` = 10.
- Reset mid-operation: with `level` = 3, pulse `rst` while `cmd_in_sync` = `out_sync` = 1 → next cycle `level` = 0, `out_notify` = 0, `delivered` = 0. The next pushed message is the first one delivered.
- Counter wrap: preload via 2^`CNT_W` pops (or force `CNT_W` = 4 and do 17 pops) → `delivered` wraps to 0 then 1.
